// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern source: pattern codes, default 640x480
// timing and moving-bar geometry.
package vga_pkg;

   localparam int COUNT_WIDTH = 10;

   localparam logic [3:0] PAT_BLACK       = 4'd0;
   localparam logic [3:0] PAT_RED         = 4'd1;
   localparam logic [3:0] PAT_GREEN       = 4'd2;
   localparam logic [3:0] PAT_BLUE        = 4'd3;
   localparam logic [3:0] PAT_CHECKER     = 4'd4;
   localparam logic [3:0] PAT_COLOUR_BARS = 4'd5;
   localparam logic [3:0] PAT_BORDER      = 4'd6;
   localparam logic [3:0] PAT_MOVING_BAR  = 4'd7;

   localparam int VIDEO_WIDTH_DEF = 3;
   localparam int TOTAL_COLS_DEF  = 800;
   localparam int TOTAL_ROWS_DEF  = 525;
   localparam int ACTIVE_COLS_DEF = 640;
   localparam int ACTIVE_ROWS_DEF = 480;

   localparam int BAR_WIDTH = 16;
   localparam int BAR_STEP  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sync_state_t;

   // The bar may run past the right edge; the caller's active-region gate clips it.
   function automatic logic in_bar(input logic [COUNT_WIDTH-1:0] col,
                                   input logic [COUNT_WIDTH-1:0] bar_pos);
      logic [COUNT_WIDTH:0] bar_end;
      bar_end = {1'b0, bar_pos} + (COUNT_WIDTH+1)'(BAR_WIDTH);
      return (col >= bar_pos) && ({1'b0, col} < bar_end);
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running column/row counters with raw active-high syncs and a frame-start
// pulse, all registered from the next count so they line up with the counts.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | just out of reset; hold (0,0) for one edge and raise syncs
// ST_RUN  | counting columns every cycle, rows on column wrap
module vga_sync_counter
   import vga_pkg::*;
#(
   parameter int TOTAL_COLS  = TOTAL_COLS_DEF,
   parameter int TOTAL_ROWS  = TOTAL_ROWS_DEF,
   parameter int ACTIVE_COLS = ACTIVE_COLS_DEF,
   parameter int ACTIVE_ROWS = ACTIVE_ROWS_DEF
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic                   o_Frame_Start,
   output logic [COUNT_WIDTH-1:0] o_Col_Count,
   output logic [COUNT_WIDTH-1:0] o_Row_Count
);

   localparam logic [COUNT_WIDTH-1:0] LAST_COL = COUNT_WIDTH'(TOTAL_COLS - 1);
   localparam logic [COUNT_WIDTH-1:0] LAST_ROW = COUNT_WIDTH'(TOTAL_ROWS - 1);
   localparam logic [COUNT_WIDTH-1:0] ACT_COLS = COUNT_WIDTH'(ACTIVE_COLS);
   localparam logic [COUNT_WIDTH-1:0] ACT_ROWS = COUNT_WIDTH'(ACTIVE_ROWS);

   sync_state_t            state_q;
   sync_state_t            state_d;
   logic [COUNT_WIDTH-1:0] col_d;
   logic [COUNT_WIDTH-1:0] row_d;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q       <= ST_IDLE;
         o_Col_Count   <= '0;
         o_Row_Count   <= '0;
         o_HSync       <= 1'b0;
         o_VSync       <= 1'b0;
         o_Frame_Start <= 1'b0;
      end else begin
         state_q       <= state_d;
         o_Col_Count   <= col_d;
         o_Row_Count   <= row_d;
         o_HSync       <= (col_d < ACT_COLS);
         o_VSync       <= (row_d < ACT_ROWS);
         o_Frame_Start <= (col_d == '0) && (row_d == '0);
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = o_Col_Count;
      row_d   = o_Row_Count;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_RUN;
            col_d   = '0;
            row_d   = '0;
         end
         ST_RUN: begin
            if (o_Col_Count == LAST_COL) begin
               col_d = '0;
               row_d = (o_Row_Count == LAST_ROW) ? '0 : o_Row_Count + 1'b1;
            end else begin
               col_d = o_Col_Count + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/vga_pattern_source.sv
// Timing and test-pattern video source feeding the sync-porch stage: counters
// and syncs from vga_sync_counter, frame-synchronous pattern switching, 1-cycle video.
module vga_pattern_source
   import vga_pkg::*;
#(
   parameter int VIDEO_WIDTH = VIDEO_WIDTH_DEF,
   parameter int TOTAL_COLS  = TOTAL_COLS_DEF,
   parameter int TOTAL_ROWS  = TOTAL_ROWS_DEF,
   parameter int ACTIVE_COLS = ACTIVE_COLS_DEF,
   parameter int ACTIVE_ROWS = ACTIVE_ROWS_DEF
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic [3:0]             i_Pattern_Sel,
   input  logic                   i_Pattern_Load,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic [COUNT_WIDTH-1:0] o_Col_Count,
   output logic [COUNT_WIDTH-1:0] o_Row_Count,
   output logic                   o_Frame_Start,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam logic [COUNT_WIDTH-1:0] ACT_COLS    = COUNT_WIDTH'(ACTIVE_COLS);
   localparam logic [COUNT_WIDTH-1:0] ACT_ROWS    = COUNT_WIDTH'(ACTIVE_ROWS);
   localparam logic [COUNT_WIDTH-1:0] ACT_COLS_M1 = COUNT_WIDTH'(ACTIVE_COLS - 1);
   localparam logic [COUNT_WIDTH-1:0] ACT_ROWS_M1 = COUNT_WIDTH'(ACTIVE_ROWS - 1);
   localparam logic [COUNT_WIDTH-1:0] SEG_LAST    = COUNT_WIDTH'(ACTIVE_COLS / 8 - 1);

   logic [3:0]             pending_q;
   logic [3:0]             pending_d;
   logic [3:0]             active_q;
   logic [3:0]             pat_eff;
   logic [COUNT_WIDTH-1:0] bar_q;
   logic [COUNT_WIDTH-1:0] bar_eff;
   logic [COUNT_WIDTH:0]   bar_sum;
   logic [COUNT_WIDTH-1:0] seg_q;
   logic [COUNT_WIDTH-1:0] seg_eff;
   logic [COUNT_WIDTH-1:0] seg_d;
   logic [2:0]             idx_q;
   logic [2:0]             idx_eff;
   logic [2:0]             idx_d;
   logic                   in_active;
   logic                   px_r;
   logic                   px_g;
   logic                   px_b;
   logic                   white;

   vga_sync_counter #(
      .TOTAL_COLS  (TOTAL_COLS),
      .TOTAL_ROWS  (TOTAL_ROWS),
      .ACTIVE_COLS (ACTIVE_COLS),
      .ACTIVE_ROWS (ACTIVE_ROWS)
   ) u_sync_counter (
      .i_Clk         (i_Clk),
      .i_Rst         (i_Rst),
      .o_HSync       (o_HSync),
      .o_VSync       (o_VSync),
      .o_Frame_Start (o_Frame_Start),
      .o_Col_Count   (o_Col_Count),
      .o_Row_Count   (o_Row_Count)
   );

   // On the frame-start cycle the pending pattern and new bar position are
   // already in effect, so pixel (0,0) is drawn with the new frame's settings.
   always_comb begin
      pending_d = pending_q;
      if (i_Pattern_Load) begin
         pending_d = i_Pattern_Sel;
      end

      pat_eff = active_q;
      bar_eff = bar_q;
      bar_sum = {1'b0, bar_q} + (COUNT_WIDTH+1)'(BAR_STEP);
      if (o_Frame_Start) begin
         pat_eff = pending_q;
         if ((pending_q == PAT_MOVING_BAR) && (active_q != PAT_MOVING_BAR)) begin
            bar_eff = '0;
         end else if (bar_sum >= (COUNT_WIDTH+1)'(ACTIVE_COLS)) begin
            bar_eff = '0;
         end else begin
            bar_eff = bar_sum[COUNT_WIDTH-1:0];
         end
      end
   end

   // Colour-bar segment tracker; forced back to bar 0 whenever col is 0.
   always_comb begin
      seg_eff = (o_Col_Count == '0) ? '0 : seg_q;
      idx_eff = (o_Col_Count == '0) ? '0 : idx_q;
      if (seg_eff == SEG_LAST) begin
         seg_d = '0;
         idx_d = idx_eff + 1'b1;
      end else begin
         seg_d = seg_eff + 1'b1;
         idx_d = idx_eff;
      end
   end

   always_comb begin
      px_r      = 1'b0;
      px_g      = 1'b0;
      px_b      = 1'b0;
      white     = 1'b0;
      in_active = (o_Col_Count < ACT_COLS) && (o_Row_Count < ACT_ROWS);
      case (pat_eff)
         PAT_RED:         px_r = 1'b1;
         PAT_GREEN:       px_g = 1'b1;
         PAT_BLUE:        px_b = 1'b1;
         PAT_CHECKER:     white = o_Col_Count[5] ^ o_Row_Count[5];
         PAT_COLOUR_BARS: {px_r, px_g, px_b} = ~idx_eff;
         PAT_BORDER:      white = (o_Row_Count == '0) || (o_Row_Count == ACT_ROWS_M1) ||
                                  (o_Col_Count == '0) || (o_Col_Count == ACT_COLS_M1);
         PAT_MOVING_BAR:  white = in_bar(o_Col_Count, bar_eff);
         default:         white = 1'b0;
      endcase
      if (white) begin
         px_r = 1'b1;
         px_g = 1'b1;
         px_b = 1'b1;
      end
      if (!in_active) begin
         px_r = 1'b0;
         px_g = 1'b0;
         px_b = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         pending_q   <= PAT_BLACK;
         active_q    <= PAT_BLACK;
         bar_q       <= '0;
         seg_q       <= '0;
         idx_q       <= '0;
         o_Red_Video <= '0;
         o_Grn_Video <= '0;
         o_Blu_Video <= '0;
      end else begin
         pending_q   <= pending_d;
         active_q    <= pat_eff;
         bar_q       <= bar_eff;
         seg_q       <= seg_d;
         idx_q       <= idx_d;
         o_Red_Video <= px_r ? '1 : '0;
         o_Grn_Video <= px_g ? '1 : '0;
         o_Blu_Video <= px_b ? '1 : '0;
      end
   end

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench: a default 640x480 instance for line timing and a reduced
// 80x10 (64x8 active) instance so whole frames fit in a short run.
module tb_vga_pattern_source;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sel;
   logic       load;

   logic       b_hs, b_vs, b_fs;
   logic [9:0] b_col, b_row;
   logic [2:0] b_r, b_g, b_b;

   logic       s_hs, s_vs, s_fs;
   logic [9:0] s_col, s_row;
   logic [2:0] s_r, s_g, s_b;
   logic [8:0] s_rgb;

   int total = 0;
   int bad   = 0;

   assign s_rgb = {s_r, s_g, s_b};

   always #5 clk = ~clk;

   vga_pattern_source u_big (
      .i_Clk          (clk),
      .i_Rst          (rst),
      .i_Pattern_Sel  (sel),
      .i_Pattern_Load (load),
      .o_HSync        (b_hs),
      .o_VSync        (b_vs),
      .o_Col_Count    (b_col),
      .o_Row_Count    (b_row),
      .o_Frame_Start  (b_fs),
      .o_Red_Video    (b_r),
      .o_Grn_Video    (b_g),
      .o_Blu_Video    (b_b)
   );

   vga_pattern_source #(
      .VIDEO_WIDTH (3),
      .TOTAL_COLS  (80),
      .TOTAL_ROWS  (10),
      .ACTIVE_COLS (64),
      .ACTIVE_ROWS (8)
   ) u_small (
      .i_Clk          (clk),
      .i_Rst          (rst),
      .i_Pattern_Sel  (sel),
      .i_Pattern_Load (load),
      .o_HSync        (s_hs),
      .o_VSync        (s_vs),
      .o_Col_Count    (s_col),
      .o_Row_Count    (s_row),
      .o_Frame_Start  (s_fs),
      .o_Red_Video    (s_r),
      .o_Grn_Video    (s_g),
      .o_Blu_Video    (s_b)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_small(input int c, input int r);
      int n;
      n = 0;
      while (!((s_col == 10'(c)) && (s_row == 10'(r))) && (n < 2000)) begin
         tick();
         n++;
      end
      chk($sformatf("wait_%0d_%0d", c, r), 32'(n < 2000), 32'd1);
   endtask

   task automatic chk_px(input string tag, input int c, input int r, input logic [8:0] exp);
      wait_small(c, r);
      tick();
      chk(tag, 32'(s_rgb), 32'(exp));
   endtask

   task automatic load_pat(input logic [3:0] code);
      sel  = code;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      int hs_hi, hs_skew, vs_hi, vs_skew, fs_cnt;
      rst  = 1'b1;
      sel  = 4'd0;
      load = 1'b0;
      repeat (10) tick();
      chk("rst_col", 32'(b_col), 0);
      chk("rst_row", 32'(b_row), 0);
      chk("rst_syncs", 32'({b_hs, b_vs, b_fs}), 0);
      chk("rst_video", 32'({b_r, b_g, b_b}), 0);
      chk("rst_small_syncs", 32'({s_hs, s_vs, s_fs}), 0);

      rst = 1'b0;
      tick();
      chk("first_counts", 32'({b_col, b_row}), 0);
      chk("first_syncs", 32'({b_hs, b_vs, b_fs}), 32'b111);
      chk("first_small_fs", 32'(s_fs), 1);

      hs_hi = 0; hs_skew = 0; vs_hi = 0; vs_skew = 0; fs_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (b_hs) hs_hi++;
         if (b_hs !== (b_col < 10'd640)) hs_skew++;
         if (s_vs) vs_hi++;
         if (s_vs !== (s_row < 10'd8)) vs_skew++;
         if ((i > 0) && s_fs) fs_cnt++;
         if (i == 799) begin
            chk("line_end_col", 32'(b_col), 799);
            chk("line_end_row", 32'(b_row), 0);
         end
         tick();
      end
      chk("wrap_col", 32'(b_col), 0);
      chk("wrap_row", 32'(b_row), 1);
      chk("hsync_high", 32'(hs_hi), 640);
      chk("hsync_skew", 32'(hs_skew), 0);
      chk("small_vsync_high", 32'(vs_hi), 640);
      chk("small_vsync_skew", 32'(vs_skew), 0);
      chk("small_fs_midframe", 32'(fs_cnt), 0);
      chk("small_fs_period", 32'({s_fs, s_col, s_row}), 32'h1_0000_0);

      // colour bars, loaded mid-frame
      wait_small(0, 4);
      load_pat(4'd5);
      chk_px("bars_not_yet", 8, 4, 9'o000);
      chk_px("bars_col8", 8, 0, 9'o770);
      chk_px("bars_col55", 55, 0, 9'o007);
      chk_px("bars_col63", 63, 0, 9'o000);
      chk_px("bars_col0", 0, 1, 9'o777);
      chk_px("bars_col64", 64, 1, 9'o000);

      // two loads in one frame: last one wins
      wait_small(10, 2);
      load_pat(4'd4);
      wait_small(10, 3);
      load_pat(4'd6);
      chk_px("bars_still", 10, 4, 9'o770);
      chk_px("border_00", 0, 0, 9'o777);
      chk_px("border_11", 1, 1, 9'o000);
      chk_px("border_63_7", 63, 7, 9'o777);

      // load coinciding with frame start
      wait_small(0, 0);
      chk("fs_on_load", 32'(s_fs), 1);
      load_pat(4'd7);
      chk_px("old_pat_row0", 32, 0, 9'o777);
      chk_px("old_pat_col63", 63, 4, 9'o777);
      wait_small(0, 0);
      chk_px("bar0_col15", 15, 2, 9'o777);
      chk_px("bar0_col16", 16, 2, 9'o000);
      chk_px("bar0_col0", 0, 3, 9'o777);
      chk_px("bar4_col3", 3, 1, 9'o000);
      chk_px("bar4_col4", 4, 1, 9'o777);
      chk_px("bar4_col19", 19, 1, 9'o777);
      chk_px("bar4_col20", 20, 1, 9'o000);
      for (int k = 0; k < 14; k++) begin
         wait_small(0, 0);
         tick();
      end
      chk_px("bar60_col59", 59, 2, 9'o000);
      chk_px("bar60_col60", 60, 2, 9'o777);
      chk_px("bar60_col63", 63, 2, 9'o777);
      wait_small(0, 0);
      chk_px("barwrap_col0", 0, 2, 9'o777);
      chk_px("barwrap_col16", 16, 2, 9'o000);

      // reset mid-frame with a pending change
      load_pat(4'd5);
      wait_small(30, 5);
      rst = 1'b1;
      tick();
      chk("midrst_counts", 32'({s_col, s_row}), 0);
      chk("midrst_syncs", 32'({s_hs, s_vs, s_fs}), 0);
      chk("midrst_video", 32'(s_rgb), 0);
      rst = 1'b0;
      tick();
      chk("after_rst_counts", 32'({s_col, s_row}), 0);
      chk("after_rst_syncs", 32'({s_hs, s_vs, s_fs}), 32'b111);
      tick();
      chk("after_rst_px00", 32'(s_rgb), 0);
      chk_px("after_rst_col8", 8, 0, 9'o000);
      chk_px("pending_dropped", 0, 0, 9'o000);

      // remaining codes
      load_pat(4'd3);
      wait_small(0, 0);
      chk_px("blue", 10, 2, 9'o007);
      load_pat(4'd4);
      wait_small(0, 0);
      chk_px("checker_col31", 31, 2, 9'o000);
      chk_px("checker_col32", 32, 2, 9'o777);
      load_pat(4'd12);
      wait_small(0, 0);
      chk_px("code12_black", 32, 2, 9'o000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
